// File: rtl/mp3_buf_pkg.sv
// Shared types and constants for the MP3 frame buffer write path.
package mp3_buf_pkg;

   localparam int unsigned DEFAULT_FRAME_BYTES = 512;

   localparam logic [7:0] SYNC_BYTE0 = 8'hFF;
   localparam logic [2:0] SYNC_MASK1 = 3'b111;

   typedef enum logic [1:0] {
      S_HUNT,
      S_HUNT2,
      S_FILL,
      S_STALL
   } buf_state_t;

   // Second header byte of an MPEG audio frame carries the tail of the sync word.
   function automatic logic is_sync_hdr(input logic [7:0] b);
      return b[7:5] == SYNC_MASK1;
   endfunction

endpackage

// File: rtl/mp3_frame_buffer_ram.sv
// Simple dual-port, single-clock block RAM with optional output register.
module xilinx_simple_dual_port_1_clock_ram #(
   parameter int unsigned RAM_WIDTH       = 8,
   parameter int unsigned RAM_DEPTH       = 4096,
   parameter              RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
   input  logic [$clog2(RAM_DEPTH)-1:0] addra,
   input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
   input  logic [RAM_WIDTH-1:0]         dina,
   input  logic                         clka,
   input  logic                         wea,
   input  logic                         enb,
   input  logic                         rstb,
   input  logic                         regceb,
   output logic [RAM_WIDTH-1:0]         doutb
);

   logic [RAM_WIDTH-1:0] bram [RAM_DEPTH];
   logic [RAM_WIDTH-1:0] ram_data;

   always_ff @(posedge clka) begin
      if (wea)
         bram[addra] <= dina;
      if (enb)
         ram_data <= bram[addrb];
   end

   if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_latency
      logic unused_ctrl;
      assign unused_ctrl = rstb ^ regceb;
      assign doutb = ram_data;
   end else begin : g_high_perf
      logic [RAM_WIDTH-1:0] dout_reg;
      always_ff @(posedge clka) begin
         if (rstb)
            dout_reg <= '0;
         else if (regceb)
            dout_reg <= ram_data;
      end
      assign doutb = dout_reg;
   end

endmodule

// File: rtl/mp3_frame_buffer.sv
// Packs a valid-qualified byte stream into fixed-size BRAM frame slots for the frame reader.
// Define MP3_FRAME_SYNC_EN to hunt for an MPEG sync word before storing after rst/flush.
module mp3_frame_buffer
   import mp3_buf_pkg::*;
#(
   parameter int unsigned FRAME_BYTES = DEFAULT_FRAME_BYTES,
   parameter int unsigned NUM_SLOTS   = 8
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [7:0]                                axiid,
   input  logic                                      axiiv,
   output logic                                      axiir,
   input  logic                                      flush,
   output logic                                      frame_v,
   output logic [$clog2(NUM_SLOTS)-1:0]              frame_slot,
   input  logic                                      frame_release,
   input  logic [$clog2(NUM_SLOTS*FRAME_BYTES)-1:0]  rd_addr,
   output logic [7:0]                                rd_data,
   output logic [$clog2(NUM_SLOTS):0]                frames_held,
   output logic                                      drop_err
);

   localparam int unsigned SW = $clog2(NUM_SLOTS);
   localparam int unsigned BW = $clog2(FRAME_BYTES);
   localparam int unsigned CW = SW + 1;
   localparam logic [CW-1:0] FULL = CW'(NUM_SLOTS);

`ifdef MP3_FRAME_SYNC_EN
   localparam buf_state_t INIT_STATE = S_HUNT;
`else
   localparam buf_state_t INIT_STATE = S_FILL;
`endif

   if ((FRAME_BYTES < 2) || ((FRAME_BYTES & (FRAME_BYTES - 1)) != 0)) begin : g_bad_frame_bytes
      $error("FRAME_BYTES must be a power of two");
   end
   if ((NUM_SLOTS < 2) || (NUM_SLOTS > 64) || ((NUM_SLOTS & (NUM_SLOTS - 1)) != 0)) begin : g_bad_num_slots
      $error("NUM_SLOTS must be a power of two in 2..64");
   end

   buf_state_t      state_q, state_d;
   logic [SW-1:0]   wr_slot_q, wr_slot_d;
   logic [SW-1:0]   rd_slot_q, rd_slot_d;
   logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
   logic [CW-1:0]   count_q, count_d;
   logic            drop_err_q;

   logic            accept;
   logic            complete;
   logic            release_ok;
   logic            wr_en;
   logic [SW+BW-1:0] wr_addr;

   always_comb begin
      axiir = 1'b0;
      if (!rst && !flush) begin
         case (state_q)
            S_FILL:  axiir = count_q < FULL;
            S_STALL: axiir = 1'b0;
            default: axiir = 1'b1;
         endcase
      end
   end

   assign accept = axiiv && axiir;

   always_comb begin
      state_d    = state_q;
      wr_slot_d  = wr_slot_q;
      rd_slot_d  = rd_slot_q;
      byte_cnt_d = byte_cnt_q;
      count_d    = count_q;
      wr_en      = 1'b0;
      wr_addr    = {wr_slot_q, byte_cnt_q};
      complete   = 1'b0;
      release_ok = frame_release && (count_q != '0);

      case (state_q)
`ifdef MP3_FRAME_SYNC_EN
         // Each candidate 0xFF is written to byte 0 as it arrives, so the header
         // byte only needs byte 1; the slot is free while hunting.
         S_HUNT: begin
            if (accept && (axiid == SYNC_BYTE0)) begin
               wr_en   = 1'b1;
               state_d = S_HUNT2;
            end
         end
         S_HUNT2: begin
            if (accept) begin
               if (axiid == SYNC_BYTE0) begin
                  wr_en = 1'b1;
               end else if (is_sync_hdr(axiid)) begin
                  wr_en      = 1'b1;
                  wr_addr    = {wr_slot_q, BW'(1)};
                  byte_cnt_d = BW'(2);
                  state_d    = S_FILL;
               end else begin
                  state_d = S_HUNT;
               end
            end
         end
`endif
         S_FILL: begin
            if (accept) begin
               wr_en      = 1'b1;
               byte_cnt_d = byte_cnt_q + BW'(1);
               complete   = (byte_cnt_q == '1);
            end
         end
         S_STALL: begin
            if (release_ok)
               state_d = S_FILL;
         end
         default: ;
      endcase

      if (complete)
         wr_slot_d = wr_slot_q + SW'(1);
      if (release_ok)
         rd_slot_d = rd_slot_q + SW'(1);

      case ({complete, release_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: ;
      endcase

      if (complete && (count_d == FULL))
         state_d = S_STALL;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state_q    <= INIT_STATE;
         wr_slot_q  <= '0;
         rd_slot_q  <= '0;
         byte_cnt_q <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         wr_slot_q  <= wr_slot_d;
         rd_slot_q  <= rd_slot_d;
         byte_cnt_q <= byte_cnt_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         drop_err_q <= 1'b0;
      else if (axiiv && !axiir)
         drop_err_q <= 1'b1;
   end

   assign frame_v     = (count_q != '0);
   assign frame_slot  = rd_slot_q;
   assign frames_held = count_q;
   assign drop_err    = drop_err_q;

   xilinx_simple_dual_port_1_clock_ram #(
      .RAM_WIDTH       (8),
      .RAM_DEPTH       (NUM_SLOTS * FRAME_BYTES),
      .RAM_PERFORMANCE ("HIGH_PERFORMANCE")
   ) u_ram (
      .addra  (wr_addr),
      .addrb  (rd_addr),
      .dina   (axiid),
      .clka   (clk),
      .wea    (wr_en),
      .enb    (1'b1),
      .rstb   (rst),
      .regceb (1'b1),
      .doutb  (rd_data)
   );

endmodule

// File: tb/tb_mp3_frame_buffer.sv
// Directed bench for mp3_frame_buffer: per-cycle control vectors plus frame-level sequences.
`timescale 1ns/1ps
module tb_mp3_frame_buffer;

   localparam int FB = 512;
   localparam int NS = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  axiid = '0;
   logic        axiiv = 1'b0;
   logic        axiir;
   logic        flush = 1'b0;
   logic        frame_v;
   logic [2:0]  frame_slot;
   logic        frame_release = 1'b0;
   logic [11:0] rd_addr = '0;
   logic [7:0]  rd_data;
   logic [3:0]  frames_held;
   logic        drop_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mp3_frame_buffer #(
      .FRAME_BYTES (FB),
      .NUM_SLOTS   (NS)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .axiid         (axiid),
      .axiiv         (axiiv),
      .axiir         (axiir),
      .flush         (flush),
      .frame_v       (frame_v),
      .frame_slot    (frame_slot),
      .frame_release (frame_release),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .frames_held   (frames_held),
      .drop_err      (drop_err)
   );

   typedef struct {
      logic       rst;
      logic       v;
      logic [7:0] d;
      logic       fl;
      logic       rel;
      logic       e_rdy;
      logic       e_v;
      logic [2:0] e_slot;
      logic [3:0] e_held;
      logic       e_drop;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      axiiv = 1'b1;
      axiid = b;
      tick();
      axiiv = 1'b0;
   endtask

   task automatic fill_frame(input int off);
      for (int i = 0; i < FB; i++)
         send(8'(i + off));
   endtask

   task automatic release_one();
      frame_release = 1'b1;
      tick();
      frame_release = 1'b0;
   endtask

   task automatic read_chk(input string name, input logic [11:0] a, input logic [7:0] exp);
      rd_addr = a;
      tick();
      tick();
      chk(name, rd_data, exp);
   endtask

   initial begin
      //            rst   v     d      fl    rel   rdy   v     slot  held  drop
      vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0};
      vecs[2] = '{1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1};
      vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 1'b1};
      vecs[5] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0};
      vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0};

      tick();
      for (int k = 0; k < 7; k++) begin
         rst           = vecs[k].rst;
         axiiv         = vecs[k].v;
         axiid         = vecs[k].d;
         flush         = vecs[k].fl;
         frame_release = vecs[k].rel;
         #1;
         chk($sformatf("v%0d_axiir", k), axiir, vecs[k].e_rdy);
         tick();
         chk($sformatf("v%0d_frame_v", k), frame_v, vecs[k].e_v);
         chk($sformatf("v%0d_slot", k), frame_slot, vecs[k].e_slot);
         chk($sformatf("v%0d_held", k), frames_held, vecs[k].e_held);
         chk($sformatf("v%0d_drop", k), drop_err, vecs[k].e_drop);
         if (k == 0)
            chk("reset_rd_data", rd_data, 8'h00);
      end
      rst = 1'b0; axiiv = 1'b0; flush = 1'b0; frame_release = 1'b0;

`ifdef MP3_FRAME_SYNC_EN
      send(8'h12);
      send(8'hFF);
      send(8'hFF);
      send(8'hFB);
      send(8'h90);
      for (int i = 3; i < FB - 1; i++)
         send(8'(i));
      chk("sync_pre_v", frame_v, 1'b0);
      send(8'hFF);
      chk("sync_v", frame_v, 1'b1);
      chk("sync_held", frames_held, 4'd1);
      read_chk("sync_a0", 12'h000, 8'hFF);
      read_chk("sync_a1", 12'h001, 8'hFB);
      read_chk("sync_a2", 12'h002, 8'h90);
      read_chk("sync_a3", 12'h003, 8'h03);
`else
      // one frame, value = index mod 256
      for (int i = 0; i < FB - 1; i++)
         send(8'(i));
      chk("a_pre_v", frame_v, 1'b0);
      send(8'hFF);
      chk("a_v", frame_v, 1'b1);
      chk("a_slot", frame_slot, 3'd0);
      chk("a_held", frames_held, 4'd1);
      read_chk("a_rd_1ff", 12'h1FF, 8'hFF);
      read_chk("a_rd_000", 12'h000, 8'h00);
      read_chk("a_rd_080", 12'h080, 8'h80);

      // fill remaining slots, ring goes full
      for (int s = 1; s < NS; s++)
         fill_frame(s);
      chk("full_axiir", axiir, 1'b0);
      chk("full_held", frames_held, 4'd8);
      chk("full_v", frame_v, 1'b1);
      axiiv = 1'b1; axiid = 8'hEE;
      tick();
      axiiv = 1'b0;
      chk("full_drop", drop_err, 1'b1);
      chk("full_held2", frames_held, 4'd8);
      read_chk("full_not_stored", 12'h000, 8'h00);
      read_chk("full_rd_605", 12'h605, 8'h08);
      release_one();
      chk("rel_axiir", axiir, 1'b1);
      chk("rel_slot", frame_slot, 3'd1);
      chk("rel_held", frames_held, 4'd7);

      // completion and release in the same cycle
      for (int r = 0; r < 4; r++)
         release_one();
      chk("c_held_pre", frames_held, 4'd3);
      chk("c_slot_pre", frame_slot, 3'd5);
      for (int i = 0; i < FB - 1; i++)
         send(8'(i + 9));
      axiiv = 1'b1; axiid = 8'h08; frame_release = 1'b1;
      tick();
      axiiv = 1'b0; frame_release = 1'b0;
      chk("c_held", frames_held, 4'd3);
      chk("c_slot", frame_slot, 3'd6);
      chk("c_v", frame_v, 1'b1);
      send(8'h5A);
      read_chk("c_wr_slot_adv", 12'h200, 8'h5A);
      read_chk("c_last_byte", 12'h1FF, 8'h08);
      chk("drop_sticky", drop_err, 1'b1);

      // reset mid-frame with a release pulse
      rst = 1'b1; frame_release = 1'b1; axiiv = 1'b1; axiid = 8'h77;
      #1;
      chk("r_axiir_in_rst", axiir, 1'b0);
      tick();
      chk("r_v", frame_v, 1'b0);
      chk("r_slot", frame_slot, 3'd0);
      chk("r_held", frames_held, 4'd0);
      chk("r_drop", drop_err, 1'b0);
      chk("r_rd_data", rd_data, 8'h00);
      rst = 1'b0; frame_release = 1'b0; axiiv = 1'b0;
      #1;
      chk("r_axiir_after", axiir, 1'b1);

      // flush partway into the third frame
      fill_frame(8'h40);
      fill_frame(8'h80);
      for (int i = 0; i < 300; i++)
         send(8'(i + 8'hA0));
      chk("f_held_pre", frames_held, 4'd2);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("f_held", frames_held, 4'd0);
      chk("f_v", frame_v, 1'b0);
      chk("f_slot", frame_slot, 3'd0);
      send(8'hC3);
      read_chk("f_addr0", 12'h000, 8'hC3);
      for (int i = 1; i < FB - 1; i++)
         send(8'(i));
      chk("f_partial_gone", frame_v, 1'b0);
      send(8'hFF);
      chk("f_v_after", frame_v, 1'b1);
      chk("f_held_after", frames_held, 4'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mp3_frame_buffer.md
# mp3_frame_buffer

Byte-stream-to-BRAM frame writer for the MP3 parser path. It accepts a valid-qualified byte stream from the SD/UART front end and packs it into fixed-size frame slots in an internal simple dual-port BRAM ring. Completed slots are offered to the downstream frame reader, which reads bytes through a read port and releases each slot when done. It is the write side of the stored-frame interface that the BRAM frame feeders read from.

## Interface
- FRAME_BYTES, 512, bytes per slot; power of two.
- NUM_SLOTS, 8, slots in ring; power of two, 2..64.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- axiid  in  8  input byte.
- axiiv  in  1  byte valid; a byte is accepted when axiiv && axiir.
- axiir  out  1  ready; low when all slots are held or while flushing.
- flush  in  1  single-cycle pulse; discard all slots and any partial frame.
- frame_v  out  1  at least one completed, unreleased slot exists.
- frame_slot  out  $clog2(NUM_SLOTS)  index of the oldest completed slot.
- frame_release  in  1  pulse; reader is done with slot frame_slot.
- rd_addr  in  $clog2(NUM_SLOTS*FRAME_BYTES)  read address, {slot, byte}.
- rd_data  out  8  read data, 2-cycle latency.
- frames_held  out  $clog2(NUM_SLOTS)+1  completed slots held.
- drop_err  out  1  sticky; set when axiiv is high while axiir is low.

## Operation
- Pointers: wr_slot, rd_slot (frame_slot), byte_cnt (0..FRAME_BYTES-1), count (= frames_held).
- Write address = (wr_slot << log2(FRAME_BYTES)) + byte_cnt. An accepted byte is written there, then byte_cnt increments.
- When the byte with byte_cnt == FRAME_BYTES-1 is accepted:
  - byte_cnt wraps to 0.
  - wr_slot increments modulo NUM_SLOTS.
  - count increments.
- frame_release with count > 0: rd_slot increments modulo NUM_SLOTS, and count decrements. A release with count == 0 is ignored.
- Simultaneous frame completion and release: count is unchanged and both pointers advance.
- FSM states:
  - S_HUNT, S_HUNT2: exist only with the macro; see Configuration.
  - S_FILL: axiir = (count < NUM_SLOTS).
  - S_STALL: entered when a completion makes count == NUM_SLOTS. axiir = 0. Returns to S_FILL on the cycle after the first release.
- flush or rst:
  - Clear wr_slot, rd_slot, byte_cnt and count.
  - Return to the initial state (S_HUNT with the macro, S_FILL without).
  - BRAM contents are untouched.
  - drop_err is cleared by rst only.
- The read port is independent. Reading a slot that is not held returns stale data; this is not checked.

## Timing
- Reset values: axiir 0 for the reset cycle, then 1; frame_v 0; frame_slot 0; frames_held 0; drop_err 0; rd_data 0 (output register reset).
- axiir is combinational from state/count, so it is valid in the same cycle the state changes.
- Completion latency: frame_v and frames_held update on the cycle after the last byte is accepted.
- Release: frame_slot and frames_held update on the cycle after the frame_release pulse.
- Read latency: rd_data is valid 2 cycles after rd_addr (HIGH_PERFORMANCE output register).
- Write-then-read of the same address through the read port returns new data if rd_addr is presented 1 or more cycles after the write cycle.
- Back-to-back bytes are accepted every cycle; no minimum gap is required.

## Configuration
- MP3_FRAME_SYNC_EN defined:
  - After rst/flush the FSM starts in S_HUNT with axiir = 1, and bytes are discarded.
  - In S_HUNT, byte 0xFF moves to S_HUNT2.
  - In S_HUNT2:
    - Byte with [7:5] == 3'b111: enter S_FILL. 0xFF is written as byte 0 and this byte as byte 1, so byte_cnt = 2.
    - Byte 0xFF: stay in S_HUNT2.
    - Any other byte: return to S_HUNT.
  - Hunting happens only once per rst/flush.
- MP3_FRAME_SYNC_EN undefined: the FSM starts in S_FILL and every accepted byte is stored. The hunt states and sync logic are absent.

## Structure
- mp3_buf_pkg holds:
  - the state enum (S_HUNT, S_HUNT2, S_FILL, S_STALL);
  - constants SYNC_BYTE0 = 8'hFF and SYNC_MASK1 = 3'b111;
  - the default FRAME_BYTES.
- One sub-module: xilinx_simple_dual_port_1_clock_ram. Parameters: RAM_WIDTH 8, RAM_DEPTH NUM_SLOTS*FRAME_BYTES, HIGH_PERFORMANCE, no init file.
- An elaboration-time check rejects a non-power-of-two FRAME_BYTES or NUM_SLOTS.

## Test plan
- Feed 512 bytes, value = index mod 256, back to back:
  - frame_v rises 1 cycle after the last byte; frame_slot 0; frames_held 1.
  - rd_addr 0x1FF gives rd_data 0xFF 2 cycles later.
- Feed 8 frames without release:
  - After the 8th frame, axiir = 0 and frames_held = 8.
  - One extra axiiv byte sets drop_err and is not stored.
  - One release gives axiir = 1 next cycle and frame_slot = 1.
- Hold a completion and a frame_release in the same cycle with frames_held = 3 -> frames_held stays 3; wr_slot and frame_slot both advance.
- Pulse flush after 300 bytes of frame 2 -> frames_held 0, frame_v 0, and the next byte lands at address 0.
- MP3_FRAME_SYNC_EN: stream 0x12, 0xFF, 0xFF, 0xFB, 0x90 ... -> the first two bytes are dropped; address 0 = 0xFF, 1 = 0xFB, 2 = 0x90.
- rst asserted mid-frame while frame_release pulses -> all outputs return to their reset values; the release is ignored.
